// File: rtl/shifter_defs.sv
// Shared definitions for the pipelined shift/rotate unit:
// operation encodings and the stage-record field widths.
package shifter_defs;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_SLL = 3'b000;
  localparam logic [OP_W-1:0] OP_SRL = 3'b001;
  localparam logic [OP_W-1:0] OP_SRA = 3'b010;
  localparam logic [OP_W-1:0] OP_ROR = 3'b011;
  localparam logic [OP_W-1:0] OP_ROL = 3'b100;

  // Stage record = {valid, data[WIDTH], op[OP_W], shift[SW], carry, msb}.
  localparam int REC_FLAG_W = 3;

  function automatic int rec_width(input int width);
    return REC_FLAG_W + width + OP_W + $clog2(width);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel level of the shift pipeline plus its handshake register.
// Level K shifts by 2**K when bit K of the piped shift amount is set.
module shift_stage
  import shifter_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 0,
  localparam int SW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [OP_W-1:0]  in_op,
  input  logic [SW-1:0]    in_shift,
  input  logic             in_carry,
  input  logic             in_msb,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [OP_W-1:0]  out_op,
  output logic [SW-1:0]    out_shift,
  output logic             out_carry,
  output logic             out_msb
);

  localparam int S = 1 << K;

  logic [WIDTH-1:0] shifted;

  // NOTE: shifted gets a default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    shifted = in_data;
    if (in_shift[K]) begin
      case (in_op)
        OP_SLL:  shifted = in_data << S;
        OP_SRL:  shifted = in_data >> S;
        // Upper bits are already sign-filled by earlier levels, so the
        // captured operand MSB is the correct fill at every level.
        OP_SRA:  shifted = (in_data >> S) | ({WIDTH{in_msb}} << (WIDTH - S));
        OP_ROR:  shifted = (in_data >> S) | (in_data << (WIDTH - S));
        OP_ROL:  shifted = (in_data << S) | (in_data >> (WIDTH - S));
        default: shifted = in_data;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every stage samples its
  // neighbour's pre-edge value; the payload is reset too so OUT reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_op    <= '0;
      out_shift <= '0;
      out_carry <= 1'b0;
      out_msb   <= 1'b0;
    end else if (load) begin
      out_valid <= in_valid;
      // Bubbles only clear valid; the payload holds its last value.
      if (in_valid) begin
        out_data  <= shifted;
        out_op    <= in_op;
        out_shift <= in_shift;
        out_carry <= in_carry;
        out_msb   <= in_msb;
      end
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined shift/rotate unit: SW registered barrel levels with a
// collapsing valid/ready chain, plus carry-out and zero flags.
module shift_pipe
  import shifter_defs::*;
#(
  parameter int WIDTH = 8,
  localparam int SW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN,
  input  logic [SW-1:0]    SHIFT,
  input  logic [OP_W-1:0]  OP,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT,
  output logic             CARRY,
  output logic             ZERO
);

  // Index 0 is the input side; index k+1 is the register of stage k.
  logic             valid_c [SW+1];
  logic [WIDTH-1:0] data_c  [SW+1];
  logic [OP_W-1:0]  op_c    [SW+1];
  logic [SW-1:0]    shift_c [SW+1];
  logic             carry_c [SW+1];
  logic             msb_c   [SW+1];
  logic [SW-1:0]    advance;

  logic [SW-1:0] lsb_idx;
  logic [SW-1:0] msb_idx;
  logic          carry_in;

  // Carry is fixed by the original operand: the last bit to leave the word.
  // Rotates reach the same bit as the matching logical shift.
  always_comb begin
    lsb_idx  = SHIFT - SW'(1);
    msb_idx  = SW'(0) - SHIFT;
    carry_in = 1'b0;
    if (SHIFT != '0) begin
      case (OP)
        OP_SLL, OP_ROL:         carry_in = IN[msb_idx];
        OP_SRL, OP_SRA, OP_ROR: carry_in = IN[lsb_idx];
        default:                carry_in = 1'b0;
      endcase
    end
  end

  assign valid_c[0] = IN_VALID;
  assign data_c[0]  = IN;
  assign op_c[0]    = OP;
  assign shift_c[0] = SHIFT;
  assign carry_c[0] = carry_in;
  assign msb_c[0]   = IN[WIDTH-1];

  // A stage may load when it is empty or its successor is moving.
  always_comb begin
    advance         = '0;
    advance[SW-1]   = ~valid_c[SW] | OUT_READY;
    for (int k = SW - 2; k >= 0; k--) begin
      advance[k] = ~valid_c[k+1] | advance[k+1];
    end
  end

  for (genvar k = 0; k < SW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .clk       (CLK),
      .rst_n     (RESETN),
      .load      (advance[k]),
      .in_valid  (valid_c[k]),
      .in_data   (data_c[k]),
      .in_op     (op_c[k]),
      .in_shift  (shift_c[k]),
      .in_carry  (carry_c[k]),
      .in_msb    (msb_c[k]),
      .out_valid (valid_c[k+1]),
      .out_data  (data_c[k+1]),
      .out_op    (op_c[k+1]),
      .out_shift (shift_c[k+1]),
      .out_carry (carry_c[k+1]),
      .out_msb   (msb_c[k+1])
    );
  end

  assign IN_READY  = advance[0];
  assign OUT_VALID = valid_c[SW];
  assign OUT       = data_c[SW];
  assign CARRY     = carry_c[SW];
  assign ZERO      = (data_c[SW] == '0);

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe at WIDTH=8 and WIDTH=32: a bit-level
// reference model feeds per-instance scoreboards checked every cycle.
module tb_shift_pipe;
  import shifter_defs::*;

  logic clk = 1'b0;
  logic rst_n;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, carry8, zero8;
  logic [7:0]  in8, out8;
  logic [2:0]  sh8, op8;

  logic        in_valid32, in_ready32, out_valid32, out_ready32, carry32, zero32;
  logic [31:0] in32, out32;
  logic [4:0]  sh32;
  logic [2:0]  op32;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [32:0] q8[$];
  logic [32:0] q32[$];

  initial forever #5 clk = ~clk;

  shift_pipe #(.WIDTH(8)) dut8 (
    .CLK(clk), .RESETN(rst_n), .IN_VALID(in_valid8), .IN_READY(in_ready8),
    .IN(in8), .SHIFT(sh8), .OP(op8), .OUT_VALID(out_valid8),
    .OUT_READY(out_ready8), .OUT(out8), .CARRY(carry8), .ZERO(zero8)
  );

  shift_pipe #(.WIDTH(32)) dut32 (
    .CLK(clk), .RESETN(rst_n), .IN_VALID(in_valid32), .IN_READY(in_ready32),
    .IN(in32), .SHIFT(sh32), .OP(op32), .OUT_VALID(out_valid32),
    .OUT_READY(out_ready32), .OUT(out32), .CARRY(carry32), .ZERO(zero32)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Bit-by-bit definition of each op; returns {carry, result}.
  function automatic logic [32:0] model(input int w, input logic [31:0] x,
                                        input int s, input logic [2:0] op);
    logic [31:0] r;
    logic        c;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (op)
        OP_SLL:  r[i] = (i >= s) ? x[i-s] : 1'b0;
        OP_SRL:  r[i] = (i + s < w) ? x[i+s] : 1'b0;
        OP_SRA:  r[i] = (i + s < w) ? x[i+s] : x[w-1];
        OP_ROR:  r[i] = x[(i + s) % w];
        OP_ROL:  r[i] = x[(i - s + w) % w];
        default: r[i] = x[i];
      endcase
    end
    c = 1'b0;
    if (s != 0) begin
      case (op)
        OP_SLL:         c = x[w-s];
        OP_SRL, OP_SRA: c = x[s-1];
        OP_ROR:         c = r[w-1];
        OP_ROL:         c = r[0];
        default:        c = 1'b0;
      endcase
    end
    return {c, r};
  endfunction

  // Scoreboard / compare process for both instances.
  initial begin
    logic        stall8, stall32;
    logic [32:0] held8, held32, exp;
    stall8 = 1'b0;
    stall32 = 1'b0;
    held8 = '0;
    held32 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q8.delete();
        q32.delete();
        stall8 = 1'b0;
        stall32 = 1'b0;
      end else begin
        if (stall8) check("hold8", {out_valid8, carry8, 24'b0, out8}, {1'b1, held8});
        if (stall32) check("hold32", {out_valid32, carry32, out32}, {1'b1, held32});
        if (out_valid8 && out_ready8) begin
          if (q8.size() == 0) check("spurious out8", out_valid8, 1'b0);
          else begin
            exp = q8.pop_front();
            check("out8 data", out8, exp[7:0]);
            check("out8 carry", carry8, exp[32]);
            check("out8 zero", zero8, exp[31:0] == 32'd0);
          end
        end
        if (out_valid32 && out_ready32) begin
          if (q32.size() == 0) check("spurious out32", out_valid32, 1'b0);
          else begin
            exp = q32.pop_front();
            check("out32 data", out32, exp[31:0]);
            check("out32 carry", carry32, exp[32]);
            check("out32 zero", zero32, exp[31:0] == 32'd0);
          end
        end
        if (in_valid8 && in_ready8) q8.push_back(model(8, 32'(in8), int'(sh8), op8));
        if (in_valid32 && in_ready32) q32.push_back(model(32, in32, int'(sh32), op32));
        stall8  = out_valid8 && !out_ready8;
        stall32 = out_valid32 && !out_ready32;
        held8   = {carry8, 24'b0, out8};
        held32  = {carry32, out32};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid8 = 1'b0;
    in_valid32 = 1'b0;
    out_ready8 = 1'b1;
    out_ready32 = 1'b1;
    n = 0;
    while ((q8.size() != 0 || q32.size() != 0 || out_valid8 || out_valid32) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain q8 empty", q8.size(), 0);
    check("drain q32 empty", q32.size(), 0);
  endtask

  task automatic run_op8(input string name, input logic [7:0] x, input logic [2:0] op,
                         input logic [2:0] sh, input logic [7:0] exp_d,
                         input logic exp_c, input logic exp_z);
    int lat;
    check({name, " model"}, model(8, 32'(x), int'(sh), op), {exp_c, 24'b0, exp_d});
    tick();
    in_valid8 = 1'b1; in8 = x; op8 = op; sh8 = sh; out_ready8 = 1'b1;
    @(negedge clk);
    check({name, " ready"}, in_ready8, 1'b1);
    tick();
    in_valid8 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid8 && lat < 20);
    check({name, " latency"}, lat, 3);
    check({name, " out"}, out8, exp_d);
    check({name, " carry"}, carry8, exp_c);
    check({name, " zero"}, zero8, exp_z);
  endtask

  task automatic run_op32(input string name, input logic [31:0] x, input logic [2:0] op,
                          input logic [4:0] sh, input logic [31:0] exp_d, input logic exp_c);
    int lat;
    check({name, " model"}, model(32, x, int'(sh), op), {exp_c, exp_d});
    tick();
    in_valid32 = 1'b1; in32 = x; op32 = op; sh32 = sh; out_ready32 = 1'b1;
    @(negedge clk);
    check({name, " ready"}, in_ready32, 1'b1);
    tick();
    in_valid32 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid32 && lat < 20);
    check({name, " latency"}, lat, 5);
    check({name, " out"}, out32, exp_d);
    check({name, " carry"}, carry32, exp_c);
  endtask

  task automatic rand8();
    in8 = 8'($urandom);
    sh8 = 3'($urandom);
    op8 = 3'($urandom_range(0, 7));
  endtask

  task automatic rand32();
    in32 = $urandom;
    sh32 = 5'($urandom);
    op32 = 3'($urandom_range(0, 7));
  endtask

  initial begin
    int acc, cnt, first, last;
    rst_n = 1'b0;
    in_valid8 = 1'b0; in8 = '0; sh8 = '0; op8 = '0; out_ready8 = 1'b1;
    in_valid32 = 1'b0; in32 = '0; sh32 = '0; op32 = '0; out_ready32 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", out_valid8, 1'b0);
    check("reset in_ready", in_ready8, 1'b1);
    check("reset out", out8, 8'h00);
    check("reset carry", carry8, 1'b0);
    check("reset zero", zero8, 1'b1);
    check("reset zero32", zero32, 1'b1);
    rst_n = 1'b1;

    // Directed ops on the 8-bit unit.
    run_op8("sll3", 8'h91, OP_SLL, 3'd3, 8'h88, 1'b0, 1'b0);
    run_op8("sll1", 8'h91, OP_SLL, 3'd1, 8'h22, 1'b1, 1'b0);
    run_op8("srl1", 8'h91, OP_SRL, 3'd1, 8'h48, 1'b1, 1'b0);
    run_op8("sra3", 8'h91, OP_SRA, 3'd3, 8'hF2, 1'b0, 1'b0);
    run_op8("ror3", 8'h91, OP_ROR, 3'd3, 8'h32, 1'b0, 1'b0);
    run_op8("rol1", 8'h91, OP_ROL, 3'd1, 8'h23, 1'b1, 1'b0);
    run_op8("ror0", 8'h91, OP_ROR, 3'd0, 8'h91, 1'b0, 1'b0);
    run_op8("rsv7", 8'h91, 3'b111, 3'd5, 8'h91, 1'b0, 1'b0);
    run_op8("sll7", 8'h01, OP_SLL, 3'd7, 8'h80, 1'b0, 1'b0);
    run_op8("srl1z", 8'h01, OP_SRL, 3'd1, 8'h00, 1'b1, 1'b1);
    run_op32("sll31_w32", 32'h1, OP_SLL, 5'd31, 32'h8000_0000, 1'b0);
    run_op32("ror1_w32", 32'h1, OP_ROR, 5'd1, 32'h8000_0000, 1'b1);
    run_op32("sra4_w32", 32'h8000_0001, OP_SRA, 5'd4, 32'hF800_0000, 1'b0);
    drain();

    // Back-to-back: 8 accepts, 8 results on consecutive cycles.
    tick();
    acc = 0; cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 14; i++) begin
      in_valid8 = (i < 8);
      rand8();
      @(negedge clk);
      if (in_valid8 && in_ready8) acc++;
      if (out_valid8) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
      tick();
    end
    check("b2b accepts", acc, 8);
    check("b2b results", cnt, 8);
    check("b2b consecutive", last - first, 7);
    drain();

    // Backpressure: pipe fills after 3 accepts, then drains on release.
    tick();
    out_ready8 = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid8 = 1'b1;
      rand8();
      @(negedge clk);
      if (in_ready8) acc++;
      tick();
    end
    check("bp accepts", acc, 3);
    check("bp in_ready low", in_ready8, 1'b0);
    check("bp out_valid", out_valid8, 1'b1);
    out_ready8 = 1'b1;
    #1;
    check("bp resume same cycle", in_ready8, 1'b1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid8) cnt++;
      tick();
      in_valid8 = 1'b0;
    end
    check("bp drained", cnt, 4);
    drain();

    // Reset with two results in flight.
    tick();
    out_ready8 = 1'b0;
    in_valid8 = 1'b1; in8 = 8'h91; op8 = OP_ROR; sh8 = 3'd3;
    @(negedge clk);
    tick();
    op8 = OP_SLL; sh8 = 3'd1;
    @(negedge clk);
    tick();
    in_valid8 = 1'b0;
    @(negedge clk);
    tick();
    check("rst pre valid", out_valid8, 1'b1);
    check("rst pre out", out8, 8'h32);
    rst_n = 1'b0;
    #1;
    check("rst mid out_valid", out_valid8, 1'b0);
    check("rst mid in_ready", in_ready8, 1'b1);
    check("rst mid out", out8, 8'h00);
    check("rst mid zero", zero8, 1'b1);
    check("rst mid carry", carry8, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready8 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no stale out", out_valid8, 1'b0);
      tick();
    end

    // Random traffic on both widths, with phases of heavy backpressure.
    for (int i = 0; i < 1200; i++) begin
      in_valid8  = ($urandom_range(0, 3) != 0);
      in_valid32 = ($urandom_range(0, 3) != 0);
      out_ready8  = (i % 300 < 150) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 3) == 0);
      out_ready32 = (i % 300 < 150) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 3) == 0);
      rand8();
      rand32();
      @(negedge clk);
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
